// File: rtl/conv_enc_out_packer.sv
// Packs the three encoder bit streams into bytes held in three lock-step byte FIFOs.
// Optional build macro CONV_PACK_MSB_FIRST_EN puts the first bit of each byte at bit 7.
module conv_enc_out_packer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned SMALL_SIZE = 1056,
  parameter int unsigned LARGE_SIZE = 6144
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       blk_size,
  input  logic       blk_start,
  input  logic       bit_valid,
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  output logic       bit_ready,
  input  logic       out_rd,
  output logic       out_rdy,
  output logic [7:0] fifo0_out,
  output logic [7:0] fifo1_out,
  output logic [7:0] fifo2_out,
  output logic       blk_done,
  output logic       err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = 13;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [2:0]      bit_idx;
  logic [2:0]      idx_use;
  logic [2:0]      pos;
  logic [BW-1:0]   blk_cnt;
  logic [BW-1:0]   last_cnt;
  logic [7:0]      sh0, sh1, sh2;
  logic [7:0]      nx0, nx1, nx2;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [7:0]      mem0 [FIFO_DEPTH];
  logic [7:0]      mem1 [FIFO_DEPTH];
  logic [7:0]      mem2 [FIFO_DEPTH];
  logic            accept, start_blk, cont_blk, last_bit, push, pop;

  assign bit_ready = (count < CW'(FIFO_DEPTH)) && (state != DONE);
  assign accept    = bit_valid & bit_ready;
  assign start_blk = accept & blk_start;
  assign cont_blk  = accept & ~blk_start & (state == RUN);
  assign last_bit  = cont_blk & (blk_cnt == last_cnt);
  assign push      = cont_blk & (bit_idx == 3'd7);
  assign out_rdy   = (count != '0);
  assign pop       = out_rd & out_rdy;

  // A block start always lands in byte position 0, discarding any partial byte.
  always_comb begin
    idx_use = start_blk ? 3'd0 : bit_idx;
`ifdef CONV_PACK_MSB_FIRST_EN
    pos = 3'd7 - idx_use;
`else
    pos = idx_use;
`endif
    nx0 = start_blk ? 8'h00 : sh0;
    nx1 = start_blk ? 8'h00 : sh1;
    nx2 = start_blk ? 8'h00 : sh2;
    nx0[pos] = d0;
    nx1[pos] = d1;
    nx2[pos] = d2;
  end

  // Block FSM, bit/byte counters and stream shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_idx  <= '0;
      blk_cnt  <= '0;
      last_cnt <= '0;
      sh0      <= '0;
      sh1      <= '0;
      sh2      <= '0;
      blk_done <= 1'b0;
      err      <= 1'b0;
    end else begin
      blk_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (blk_start) state <= RUN;
            else           err   <= 1'b1;
          end
        end
        RUN: begin
          if (start_blk) begin
            err <= 1'b1;
          end else if (last_bit) begin
            state    <= DONE;
            blk_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (start_blk) begin
        bit_idx  <= 3'd1;
        blk_cnt  <= BW'(1);
        last_cnt <= blk_size ? BW'(LARGE_SIZE - 1) : BW'(SMALL_SIZE - 1);
      end else if (cont_blk) begin
        bit_idx <= bit_idx + 3'd1;
        blk_cnt <= blk_cnt + BW'(1);
      end

      if (start_blk || cont_blk) begin
        sh0 <= nx0;
        sh1 <= nx1;
        sh2 <= nx2;
      end
    end
  end

  // Shared FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem0[wr_ptr] <= nx0;
      mem1[wr_ptr] <= nx1;
      mem2[wr_ptr] <= nx2;
    end
  end

  assign fifo0_out = out_rdy ? mem0[rd_ptr] : 8'h00;
  assign fifo1_out = out_rdy ? mem1[rd_ptr] : 8'h00;
  assign fifo2_out = out_rdy ? mem2[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_conv_enc_out_packer.sv
// Scoreboard bench for conv_enc_out_packer; honours CONV_PACK_MSB_FIRST_EN for expected bytes.
module tb_conv_enc_out_packer;

`ifdef CONV_PACK_MSB_FIRST_EN
  localparam logic [7:0] A2 = 8'hAA, B0 = 8'hE0, B1 = 8'h80, B2 = 8'h55;
`else
  localparam logic [7:0] A2 = 8'h55, B0 = 8'h07, B1 = 8'h01, B2 = 8'hAA;
`endif
  localparam logic [23:0] EXP_A = {8'hFF, 8'h00, A2};
  localparam logic [23:0] EXP_B = {B0, B1, B2};

  logic clk = 1'b0;
  logic rst_n, blk_size, blk_start, bit_valid, d0, d1, d2, bit_ready;
  logic out_rd, out_rdy, blk_done, err;
  logic [7:0] fifo0_out, fifo1_out, fifo2_out;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int popped = 0;
  logic rd_en = 1'b0;
  logic [23:0] sb[$];

  conv_enc_out_packer dut (
    .clk(clk), .rst_n(rst_n), .blk_size(blk_size), .blk_start(blk_start),
    .bit_valid(bit_valid), .d0(d0), .d1(d1), .d2(d2), .bit_ready(bit_ready),
    .out_rd(out_rd), .out_rdy(out_rdy), .fifo0_out(fifo0_out),
    .fifo1_out(fifo1_out), .fifo2_out(fifo2_out), .blk_done(blk_done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares the head bytes against the scoreboard whenever a pop happens.
  always @(negedge clk) begin
    #4;
    if (rst_n && out_rd && out_rdy) begin
      checks++;
      popped++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0h expected none", {fifo0_out, fifo1_out, fifo2_out});
      end else begin
        logic [23:0] e;
        e = sb.pop_front();
        if ({fifo0_out, fifo1_out, fifo2_out} !== e) begin
          errors++;
          $display("FAIL pop_data: got %0h expected %0h", {fifo0_out, fifo1_out, fifo2_out}, e);
        end
      end
    end
  end

  always @(negedge clk) if (rst_n && blk_done) done_cnt++;

  // Returns {d0,d1,d2} for bit k of a block under pattern p.
  function automatic logic [2:0] pat_bits(input int p, input int k);
    logic [2:0] m;
    m = 3'(k);
    if (p == 0) return {1'b1, 1'b0, ~m[0]};
    return {(m < 3'd3), (m == 3'd0), m[0]};
  endfunction

  // Called at negedge+1; holds the bit until accepted, returns at the next negedge+1.
  task automatic drive_bit(input logic [2:0] b, input logic s);
    int w;
    w = 0;
    bit_valid = 1'b1; blk_start = s;
    {d0, d1, d2} = b;
    out_rd = rd_en;
    #3;
    while (!bit_ready && w < 200) begin
      @(negedge clk); #1; out_rd = rd_en; #3;
      w++;
    end
    if (!bit_ready) chk("bit_accept_timeout", 32'(bit_ready), 32'd1);
    @(negedge clk); #1;
    bit_valid = 1'b0; blk_start = 1'b0;
    out_rd = rd_en;
  endtask

  task automatic send_range(input int p, input int k0, input int k1, input logic s);
    for (int k = k0; k < k1; k++) drive_bit(pat_bits(p, k), s && (k == k0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1; out_rd = rd_en;
    end
  endtask

  task automatic drain(input string nm);
    int w;
    w = 0;
    rd_en = 1'b1;
    while (sb.size() != 0 && w < 100) begin idle(1); w++; end
    idle(3);
    chk(nm, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bit_valid = 1'b0; blk_start = 1'b0; out_rd = 1'b0;
    rd_en = 1'b0; {d0, d1, d2} = 3'b000;
    repeat (2) @(negedge clk);
    sb.delete();
    rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  initial begin
    blk_size = 1'b0;
    do_reset();
    chk("rst_bit_ready", 32'(bit_ready), 32'd1);
    chk("rst_out_rdy", 32'(out_rdy), 32'd0);
    chk("rst_blk_done", 32'(blk_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_fifo_out", {8'h00, fifo0_out, fifo1_out, fifo2_out}, 32'd0);

    // Reset mid-block with bytes buffered.
    blk_size = 1'b1;
    send_range(1, 0, 20, 1'b1);
    chk("mid_out_rdy", 32'(out_rdy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_rdy", 32'(out_rdy), 32'd0);
    chk("mid_rst_bit_ready", 32'(bit_ready), 32'd1);
    chk("mid_rst_fifo_out", {8'h00, fifo0_out, fifo1_out, fifo2_out}, 32'd0);
    chk("mid_rst_err_done", {30'd0, err, blk_done}, 32'd0);
    do_reset();
    chk("mid_rst_no_done", 32'(done_cnt), 32'd0);

    // Bits in IDLE without blk_start are dropped and flag err.
    rd_en = 1'b1;
    for (int k = 0; k < 8; k++) drive_bit(pat_bits(0, k), 1'b0);
    idle(2);
    chk("idle_err", 32'(err), 32'd1);
    chk("idle_no_byte", 32'(out_rdy), 32'd0);
    chk("idle_no_pop", 32'(popped), 32'd0);
    do_reset();
    chk("err_cleared_by_reset", 32'(err), 32'd0);

    // Small block, continuous reads.
    blk_size = 1'b0; rd_en = 1'b1;
    for (int i = 0; i < 132; i++) sb.push_back(EXP_A);
    send_range(0, 0, 1056, 1'b1);
    chk("small_blk_done_pulse", 32'(blk_done), 32'd1);
    chk("small_out_rdy_last", 32'(out_rdy), 32'd1);
    chk("small_bit_ready_done", 32'(bit_ready), 32'd0);
    idle(1);
    chk("small_blk_done_clear", 32'(blk_done), 32'd0);
    drain("small_drain");
    chk("small_done_cnt", 32'(done_cnt), 32'd1);
    chk("small_popped", 32'(popped), 32'd132);
    chk("small_err", 32'(err), 32'd0);

    // Large block with reads stalled until the FIFOs fill.
    blk_size = 1'b1; rd_en = 1'b0; popped = 0;
    for (int i = 0; i < 768; i++) sb.push_back(EXP_B);
    send_range(1, 0, 128, 1'b1);
    chk("full_bit_ready", 32'(bit_ready), 32'd0);
    chk("full_out_rdy", 32'(out_rdy), 32'd1);
    rd_en = 1'b1;
    bit_valid = 1'b1; {d0, d1, d2} = pat_bits(1, 128); out_rd = 1'b1;
    #3;
    chk("full_pop_same_cycle", 32'(bit_ready), 32'd0);
    @(negedge clk); #1; #3;
    chk("ready_after_pop", 32'(bit_ready), 32'd1);
    @(negedge clk); #1;
    bit_valid = 1'b0; out_rd = rd_en;
    send_range(1, 129, 6144, 1'b0);
    drain("large_drain");
    chk("large_popped", 32'(popped), 32'd768);
    chk("large_done_cnt", 32'(done_cnt), 32'd2);

    // Reads against an empty FIFO are ignored.
    rd_en = 1'b1;
    idle(4);
    chk("empty_out_rdy", 32'(out_rdy), 32'd0);
    chk("empty_fifo_out", {8'h00, fifo0_out, fifo1_out, fifo2_out}, 32'd0);
    chk("empty_popped", 32'(popped), 32'd768);
    chk("empty_err", 32'(err), 32'd0);

    // Restart with blk_start at bit 500 of a running block.
    do_reset();
    blk_size = 1'b0; rd_en = 1'b1; popped = 0; done_cnt = 0;
    for (int i = 0; i < 62 + 132; i++) sb.push_back(EXP_A);
    send_range(0, 0, 500, 1'b1);
    chk("pre_restart_err", 32'(err), 32'd0);
    send_range(0, 0, 1056, 1'b1);
    drain("restart_drain");
    chk("restart_err", 32'(err), 32'd1);
    chk("restart_popped", 32'(popped), 32'd194);
    chk("restart_done_cnt", 32'(done_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
